// File: rtl/grid_pkg.sv
// Shared defaults and state encoding for the trail grid block.
package grid_pkg;

   localparam int GRID_W_DEF  = 75;
   localparam int GRID_H_DEF  = 75;
   localparam int COLOR_W_DEF = 24;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/grid_ram_dp.sv
// Simple dual-port cell store: port A read-first read/write, port B registered read.
// The array itself carries no reset; only the port-B output register does.
module grid_ram_dp #(
   parameter int            DEPTH = 5625,
   parameter int            AW    = 13,
   parameter int            DW    = 24,
   parameter logic [DW-1:0] FILL  = {DW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   output logic [DW-1:0] q_a,
   input  logic [AW-1:0] addr_b,
   input  logic          fill_b,
   output logic [DW-1:0] q_b
);

   logic [DW-1:0] mem_r [DEPTH];

   // Port A: the old contents are captured on the same edge that stores new data.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem_r[addr_a] <= din_a;
      end
      q_a <= mem_r[addr_a];
   end

   // Port B: registered read; fill_b substitutes the empty colour for off-grid reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_b <= FILL;
      end else if (fill_b) begin
         q_b <= FILL;
      end else begin
         q_b <= mem_r[addr_b];
      end
   end

endmodule

// File: rtl/trail_grid.sv
// Trail grid: colour-cell store with a write-and-check port A, a display read
// port B, and a full-grid clear sweep that also runs after every reset.
module trail_grid
   import grid_pkg::*;
#(
   parameter int                 GRID_W   = GRID_W_DEF,
   parameter int                 GRID_H   = GRID_H_DEF,
   parameter int                 COLOR_W  = COLOR_W_DEF,
   parameter logic [COLOR_W-1:0] BG_COLOR = {COLOR_W{1'b0}},
   localparam int                XW       = $clog2(GRID_W),
   localparam int                YW       = $clog2(GRID_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_start,
   output logic               busy,
   output logic               clr_done,
   input  logic               a_req,
   input  logic [XW-1:0]      x_a,
   input  logic [YW-1:0]      y_a,
   input  logic [COLOR_W-1:0] din_a,
   output logic               a_ready,
   output logic               a_done,
   output logic               a_hit,
   output logic               a_oob,
   input  logic [XW-1:0]      x_b,
   input  logic [YW-1:0]      y_b,
   output logic [COLOR_W-1:0] dout_b
);

   localparam int            DEPTH   = GRID_W * GRID_H;
   localparam int            AW      = $clog2(DEPTH);
   localparam int            LAST_I  = DEPTH - 1;
   localparam logic [AW-1:0] LAST_C  = LAST_I[AW-1:0];
   localparam logic [AW-1:0] W_C     = GRID_W[AW-1:0];
   localparam logic [XW:0]   X_LIM_C = GRID_W[XW:0];
   localparam logic [YW:0]   Y_LIM_C = GRID_H[YW:0];

   function automatic logic out_of_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ({1'b0, x} >= X_LIM_C) || ({1'b0, y} >= Y_LIM_C);
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return AW'(y) * W_C + AW'(x);
   endfunction

   state_e             state_r;
   logic [AW-1:0]      cnt_r;
   logic               clr_done_r;
   logic               a_done_r;
   logic               pend_oob_r;
   logic               a_hit_r;
   logic               a_oob_r;
   logic               oob_a_s;
   logic               oob_b_s;
   logic               accept_s;
   logic               hit_now_s;
   logic               we_a_s;
   logic [AW-1:0]      req_addr_s;
   logic [AW-1:0]      addr_a_s;
   logic [AW-1:0]      addr_b_s;
   logic [COLOR_W-1:0] wd_a_s;
   logic [COLOR_W-1:0] q_a_s;

   // Off-grid coordinates are steered to cell 0 so the array is never indexed past its depth.
   assign oob_a_s    = out_of_grid(x_a, y_a);
   assign oob_b_s    = out_of_grid(x_b, y_b);
   assign req_addr_s = oob_a_s ? {AW{1'b0}} : cell_addr(x_a, y_a);
   assign addr_b_s   = oob_b_s ? {AW{1'b0}} : cell_addr(x_b, y_b);
   assign accept_s   = a_req && (state_r == IDLE);
   assign hit_now_s  = pend_oob_r || (q_a_s != BG_COLOR);

   // Port A owner: the sweep while clearing, otherwise an accepted in-grid request.
   always_comb begin
      we_a_s   = 1'b0;
      addr_a_s = req_addr_s;
      wd_a_s   = din_a;
      if (state_r == CLEAR) begin
         we_a_s   = 1'b1;
         addr_a_s = cnt_r;
         wd_a_s   = BG_COLOR;
      end else if (accept_s && !oob_a_s) begin
         we_a_s = 1'b1;
      end else begin
         we_a_s = 1'b0;
      end
   end

   // Control FSM, sweep counter and request result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= CLEAR;
         cnt_r      <= {AW{1'b0}};
         clr_done_r <= 1'b0;
         a_done_r   <= 1'b0;
         pend_oob_r <= 1'b0;
         a_hit_r    <= 1'b0;
         a_oob_r    <= 1'b0;
      end else begin
         clr_done_r <= 1'b0;
         a_done_r   <= accept_s;
         pend_oob_r <= accept_s && oob_a_s;
         if (a_done_r) begin
            a_hit_r <= hit_now_s;
            a_oob_r <= pend_oob_r;
         end
         case (state_r)
            IDLE: begin
               if (clr_start) begin
                  state_r <= CLEAR;
                  cnt_r   <= {AW{1'b0}};
               end
            end
            CLEAR: begin
               if (cnt_r == LAST_C) begin
                  state_r    <= IDLE;
                  cnt_r      <= {AW{1'b0}};
                  clr_done_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + {{(AW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r <= CLEAR;
               cnt_r   <= {AW{1'b0}};
            end
         endcase
      end
   end

   // The read-first value only exists in the a_done cycle; afterwards the held copy is shown.
   assign a_done   = a_done_r;
   assign a_hit    = a_done_r ? hit_now_s : a_hit_r;
   assign a_oob    = a_done_r ? pend_oob_r : a_oob_r;
   assign clr_done = clr_done_r;
   assign busy     = (state_r == CLEAR);
   assign a_ready  = (state_r == IDLE);

   grid_ram_dp #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (COLOR_W),
      .FILL  (BG_COLOR)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .we_a   (we_a_s),
      .addr_a (addr_a_s),
      .din_a  (wd_a_s),
      .q_a    (q_a_s),
      .addr_b (addr_b_s),
      .fill_b (oob_b_s),
      .q_b    (dout_b)
   );

endmodule

// File: tb/tb_trail_grid.sv
// Bench for trail_grid: a cell-array model checked every cycle, plus directed
// checks with hand-computed values on the default grid and an 8x4 grid.
module tb_trail_grid;

   localparam int W = 75;
   localparam int H = 75;
   localparam int N = W * H;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr_start, a_req;
   logic [6:0]  x_a, y_a, x_b, y_b;
   logic [23:0] din_a, dout_b;
   logic        busy, clr_done, a_ready, a_done, a_hit, a_oob;

   logic        rst2, clr2, a_req2;
   logic [2:0]  x_a2, xb2;
   logic [1:0]  y_a2, yb2;
   logic [11:0] din2, dout2;
   logic        busy2, clr_done2, a_ready2, a_done2, a_hit2, a_oob2;

   trail_grid dut (
      .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
      .a_req(a_req), .x_a(x_a), .y_a(y_a), .din_a(din_a), .a_ready(a_ready),
      .a_done(a_done), .a_hit(a_hit), .a_oob(a_oob),
      .x_b(x_b), .y_b(y_b), .dout_b(dout_b)
   );

   trail_grid #(.GRID_W(8), .GRID_H(4), .COLOR_W(12)) dut2 (
      .clk(clk), .rst(rst2), .clr_start(clr2), .busy(busy2), .clr_done(clr_done2),
      .a_req(a_req2), .x_a(x_a2), .y_a(y_a2), .din_a(din2), .a_ready(a_ready2),
      .a_done(a_done2), .a_hit(a_hit2), .a_oob(a_oob2),
      .x_b(xb2), .y_b(yb2), .dout_b(dout2)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
   endtask

   // Model: the grid as a plain array; memory is undefined until swept after a reset.
   logic [23:0] mem_m [N];
   bit          known_m [N];
   bit          m_on = 1'b0;
   bit          m_busy, m_done, m_hit, m_oob, m_clrdone, m_dout_ok, m_hit_ok;
   int          m_pos;
   logic [23:0] m_dout;

   always @(posedge clk) begin : model
      int a;
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b1; m_pos = 0;
         m_done = 1'b0; m_hit = 1'b0; m_oob = 1'b0; m_hit_ok = 1'b1;
         m_clrdone = 1'b0; m_dout = 24'h0; m_dout_ok = 1'b1;
         for (int i = 0; i < N; i++) known_m[i] = 1'b0;
      end else if (m_on) begin
         if (int'(x_b) >= W || int'(y_b) >= H) begin
            m_dout = 24'h0; m_dout_ok = 1'b1;
         end else begin
            a = int'(y_b) * W + int'(x_b);
            m_dout = mem_m[a]; m_dout_ok = known_m[a];
         end
         m_done = 1'b0; m_clrdone = 1'b0;
         if (!m_busy) begin
            if (a_req) begin
               m_done = 1'b1;
               if (int'(x_a) >= W || int'(y_a) >= H) begin
                  m_hit = 1'b1; m_oob = 1'b1; m_hit_ok = 1'b1;
               end else begin
                  a = int'(y_a) * W + int'(x_a);
                  m_hit = (mem_m[a] != 24'h0); m_hit_ok = known_m[a]; m_oob = 1'b0;
                  mem_m[a] = din_a; known_m[a] = 1'b1;
               end
            end
            if (clr_start) begin
               m_busy = 1'b1; m_pos = 0;
            end
         end else begin
            mem_m[m_pos] = 24'h0; known_m[m_pos] = 1'b1; m_pos++;
            if (m_pos == N) begin
               m_busy = 1'b0; m_clrdone = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of the default-grid DUT against the model.
   always @(posedge clk) begin
      #1;
      if (m_on) begin
         check("cyc_busy", busy, m_busy);
         check("cyc_a_ready", a_ready, !m_busy);
         check("cyc_a_done", a_done, m_done);
         check("cyc_clr_done", clr_done, m_clrdone);
         check("cyc_a_oob", a_oob, m_oob);
         if (m_hit_ok) check("cyc_a_hit", a_hit, m_hit);
         if (m_dout_ok) check("cyc_dout_b", dout_b, m_dout);
      end
   end

   task automatic req(input int x, input int y, input logic [23:0] d);
      a_req = 1'b1; x_a = 7'(x); y_a = 7'(y); din_a = d;
      @(negedge clk);
      a_req = 1'b0;
   endtask

   task automatic read_b(input int x, input int y, output logic [23:0] d);
      x_b = 7'(x); y_b = 7'(y);
      @(negedge clk);
      d = dout_b;
   endtask

   task automatic sweep_b(output int nz);
      logic [23:0] d;
      nz = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            read_b(x, y, d);
            if (d !== 24'h0) nz++;
         end
   endtask

   // Counts busy cycles from the current negedge until clr_done, bounded.
   task automatic wait_sweep(output int busy_n, output int pulses);
      busy_n = 0; pulses = 0;
      for (int i = 0; i < 20000; i++) begin
         if (busy) busy_n++;
         if (clr_done) begin
            pulses++;
            break;
         end
         @(negedge clk);
      end
      repeat (3) begin
         @(negedge clk);
         if (clr_done) pulses++;
      end
   endtask

   initial begin
      int bn, pn, nz;
      logic [23:0] d;
      rst = 1'b1; clr_start = 1'b0; a_req = 1'b0; x_a = 7'd0; y_a = 7'd0;
      din_a = 24'h0; x_b = 7'd0; y_b = 7'd0;
      rst2 = 1'b1; clr2 = 1'b0; a_req2 = 1'b0; x_a2 = 3'd0; y_a2 = 2'd0;
      din2 = 12'h0; xb2 = 3'd0; yb2 = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1); check("rst_a_ready", a_ready, 0);
      check("rst_a_done", a_done, 0); check("rst_a_hit", a_hit, 0);
      check("rst_a_oob", a_oob, 0); check("rst_clr_done", clr_done, 0);
      check("rst_dout_b", dout_b, 24'h0);
      rst = 1'b0;
      wait_sweep(bn, pn);
      check("init_sweep_len", bn, 5625);
      check("init_clr_pulses", pn, 1);
      check("init_a_ready", a_ready, 1);
      sweep_b(nz);
      check("init_nonbg_cells", nz, 0);

      req(10, 20, 24'hFF0000);
      check("w1_done", a_done, 1); check("w1_hit", a_hit, 0); check("w1_oob", a_oob, 0);
      req(10, 20, 24'h00FF00);
      check("w2_done", a_done, 1); check("w2_hit", a_hit, 1);
      @(negedge clk);
      check("w2_done_pulse", a_done, 0); check("w2_hit_held", a_hit, 1);
      read_b(10, 20, d);
      check("rd_10_20", d, 24'h00FF00);

      // Port B on the cell being written returns the pre-write value.
      x_b = 7'd10; y_b = 7'd20;
      req(10, 20, 24'h0000FF);
      check("same_cycle_old", dout_b, 24'h00FF00);
      read_b(10, 20, d);
      check("rd_10_20_new", d, 24'h0000FF);

      req(75, 3, 24'h123456);
      check("oob_done", a_done, 1); check("oob_hit", a_hit, 1); check("oob_flag", a_oob, 1);
      read_b(75, 3, d);
      check("oob_rd", d, 24'h0);
      sweep_b(nz);
      check("cells_after_oob", nz, 1);

      clr_start = 1'b1; a_req = 1'b1; x_a = 7'd0; y_a = 7'd0; din_a = 24'hABCDEF;
      @(negedge clk);
      clr_start = 1'b0; a_req = 1'b0;
      check("cs_done", a_done, 1); check("cs_hit", a_hit, 0); check("cs_oob", a_oob, 0);
      check("cs_busy", busy, 1);
      a_req = 1'b1; x_a = 7'd1; y_a = 7'd1; din_a = 24'h777777; clr_start = 1'b1;
      @(negedge clk);
      a_req = 1'b0; clr_start = 1'b0;
      check("busy_req_no_done", a_done, 0);
      wait_sweep(bn, pn);
      check("clr_sweep_len", bn, 5624);
      check("clr_pulses", pn, 1);
      read_b(0, 0, d);
      check("rd_0_0_cleared", d, 24'h0);

      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      repeat (3000) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midsweep_rst_dout", dout_b, 24'h0);
      rst = 1'b0;
      wait_sweep(bn, pn);
      check("restart_sweep_len", bn, 5625);
      check("restart_clr_pulses", pn, 1);

      rst2 = 1'b0;
      bn = 0;
      for (int i = 0; i < 200; i++) begin
         if (busy2) bn++;
         if (clr_done2) break;
         @(negedge clk);
      end
      check("g8x4_sweep_len", bn, 32);
      @(negedge clk);
      check("g8x4_ready", a_ready2, 1);
      a_req2 = 1'b1; x_a2 = 3'd7; y_a2 = 2'd3; din2 = 12'hABC;
      @(negedge clk);
      a_req2 = 1'b0;
      check("g8x4_done", a_done2, 1); check("g8x4_oob", a_oob2, 0); check("g8x4_hit", a_hit2, 0);
      a_req2 = 1'b1; din2 = 12'h123;
      @(negedge clk);
      a_req2 = 1'b0;
      check("g8x4_rehit", a_hit2, 1); check("g8x4_reoob", a_oob2, 0);
      xb2 = 3'd7; yb2 = 2'd3;
      @(negedge clk);
      check("g8x4_rd", dout2, 12'h123);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/trail_grid.md
TRAIL_GRID -- requirements
Module: trail_grid

Interface
REQ-001 SHALL have parameter GRID_W, default 75, meaning grid width in cells.
REQ-002 SHALL have parameter GRID_H, default 75, meaning grid height in cells.
REQ-003 SHALL have parameter COLOR_W, default 24, meaning cell colour width.
REQ-004 SHALL have parameter BG_COLOR, default 0, meaning the empty-cell colour.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset; asynchronous, active-high.
REQ-007 SHALL have port clr_start, input, 1, a pulse that requests a full-grid clear.
REQ-008 SHALL have port busy, output, 1, high while a clear sweep runs.
REQ-009 SHALL have port clr_done, output, 1, a one-cycle pulse at clear completion.
REQ-010 SHALL have ports a_req (input, 1), x_a (input, XW=$clog2(GRID_W)), y_a (input, YW=$clog2(GRID_H)) and din_a (input, COLOR_W), the write-with-check request.
REQ-011 SHALL have port a_ready, output, 1, meaning port A accepts a request this cycle.
REQ-012 SHALL have ports a_done, a_hit and a_oob (outputs, 1 each), the request result.
REQ-013 SHALL have ports x_b (input, XW), y_b (input, YW) and dout_b (output, COLOR_W), the display read port.

Function
REQ-014 Cell address SHALL be y*GRID_W+x, AW=$clog2(GRID_W*GRID_H) bits wide, with storage depth exactly GRID_W*GRID_H entries.
REQ-015 a_ready SHALL equal (state==IDLE); a request SHALL be accepted only when a_req and a_ready are both high.
REQ-016 For an accepted in-bounds request, the cell SHALL be read-first: the old value is captured and din_a is written in the same cycle.
REQ-017 One cycle after acceptance, a_done SHALL pulse for 1 cycle, with a_hit=(old!=BG_COLOR) and a_oob=0.
REQ-018 An out-of-bounds request (x_a>=GRID_W or y_a>=GRID_H) SHALL perform no write; one cycle later a_done=1, a_hit=1 and a_oob=1.
REQ-019 a_hit and a_oob SHALL hold their values until the next a_done.
REQ-020 Port B SHALL have 1-cycle read latency; dout_b SHALL equal BG_COLOR for out-of-bounds coordinates.
REQ-021 A port-B read of the cell written by port A in the same cycle SHALL return the old value.
REQ-022 The state machine SHALL have two states, IDLE and CLEAR; busy=(state==CLEAR).
REQ-023 In IDLE, clr_start SHALL move the state to CLEAR on the next edge with the sweep counter at 0.
REQ-024 An a_req accepted in the same cycle as clr_start SHALL complete normally, including its a_done pulse.
REQ-025 In CLEAR, the block SHALL write BG_COLOR to address cnt each cycle, for cnt=0..GRID_W*GRID_H-1, taking exactly GRID_W*GRID_H cycles.
REQ-026 On the last sweep write, the state SHALL return to IDLE, and clr_done SHALL be 1 in the first IDLE cycle.
REQ-027 clr_start during CLEAR SHALL be ignored (no restart); a_req during CLEAR SHALL be ignored and produce no a_done.
REQ-028 Port B SHALL remain readable during CLEAR and return current memory contents.

Reset
REQ-029 On rst: state=CLEAR, cnt=0, a_done=0, a_hit=0, a_oob=0, clr_done=0, dout_b=BG_COLOR.
REQ-030 On rst release, the automatic sweep SHALL run; memory contents are defined only after its clr_done.
REQ-031 rst asserted mid-sweep or mid-request SHALL abort the activity and restart the sweep from address 0.

Structure
REQ-032 Package grid_pkg SHALL hold the default GRID_W, GRID_H and COLOR_W values and the state enum (IDLE, CLEAR).
REQ-033 Storage SHALL be a sub-module grid_ram_dp: a simple dual-port block RAM with read-first port A and registered port B, no reset on the array.
REQ-034 The address multiply, bounds check and sweep counter SHALL be in trail_grid.

Verification
REQ-035 Reset, then hold requests: busy high for 5625 cycles, clr_done pulses once, then a_ready=1, and a port-B sweep of all cells returns 0.
REQ-036 Write (10,20) with 0xFF0000 -> next cycle a_done=1, a_hit=0; rewrite (10,20) with 0x00FF00 -> a_hit=1; then port-B read of (10,20) gives 0x00FF00 one cycle later.
REQ-037 Request at (75,3) -> a_done=1, a_hit=1, a_oob=1; port-B read of (75,3) returns 0; no cell is modified.
REQ-038 clr_start and a_req at (0,0) in the same cycle -> a_done pulses; after clr_done, (0,0) reads 0; a_req issued during busy produces no a_done.
REQ-039 Assert rst at sweep cycle 3000 -> sweep restarts at address 0; clr_done follows 5625 cycles after rst release.
REQ-040 Parameter set GRID_W=8, GRID_H=4, COLOR_W=12 -> sweep length 32 cycles, and (7,3) is in bounds while (8,0) is out of bounds.
